// File: rtl/pb_irq_pkg.sv
// Shared constants for the pushbutton interrupt controller: register offsets,
// ID register layout, reset mask and the priority encoder helper.
package pb_irq_pkg;

  localparam int unsigned NUM_PB = 16;

  localparam logic [2:0] OFF_PEND_L  = 3'd0;
  localparam logic [2:0] OFF_PEND_H  = 3'd1;
  localparam logic [2:0] OFF_MASK_L  = 3'd2;
  localparam logic [2:0] OFF_MASK_H  = 3'd3;
  localparam logic [2:0] OFF_ID      = 3'd4;
  localparam logic [2:0] OFF_LEVEL_L = 3'd5;
  localparam logic [2:0] OFF_LEVEL_H = 3'd6;

  localparam int unsigned ID_VALID_BIT = 7;
  localparam int unsigned ID_IDX_W     = 4;

  localparam logic [NUM_PB-1:0] MASK_RST = 16'hFFFF;

  // Lowest set bit wins; scanning downward leaves the lowest index last.
  function automatic logic [ID_IDX_W-1:0] lowest_idx(input logic [NUM_PB-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_PB - 1; i >= 0; i--)
      if (v[i]) lowest_idx = ID_IDX_W'(i);
  endfunction

endpackage

// File: rtl/pb_irq_controller_if.sv
// CPU-side register window bus of the pushbutton interrupt controller.
interface pb_irq_controller_if;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        read_en;
  logic [7:0]  dout;
  logic        sel;

  modport master (output addr, din, read_en, input  dout, sel);
  modport slave  (input  addr, din, read_en, output dout, sel);
endinterface

// File: rtl/pb_debouncer.sv
// One-bit 2-flop synchroniser plus stability-counter debouncer.
module pb_debouncer #(
  parameter int unsigned DEBOUNCE = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  logic             r_s1, r_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(DEBOUNCE - 1));
  assign level  = r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s  <= r_s1;
      if (r_s == r_level) begin
        r_cnt <= '0;
      end else if (w_last) begin
        r_level <= r_s;
        r_cnt   <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pb_irq_controller.sv
// Debounced, maskable pushbutton interrupt source with a small memory-mapped
// register window (pending W1C, mask, ID, debounced levels).
module pb_irq_controller
  import pb_irq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hF010,
  parameter int unsigned DEBOUNCE  = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PB-1:0] pb,
  pb_irq_controller_if.slave bus,
  output logic              irq
);

  logic [NUM_PB-1:0] w_deb, r_deb_q, w_rise;
  logic [NUM_PB-1:0] r_pending, r_mask, w_active, w_clr;
  logic              r_irq;
  logic [2:0]        w_off;
  logic              w_sel, w_wr;
  logic [7:0]        w_id, w_rdata;

  genvar g;
  for (g = 0; g < NUM_PB; g++) begin : g_deb
    pb_debouncer #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (pb[g]),
      .level (w_deb[g])
    );
  end

  assign w_rise   = w_deb & ~r_deb_q;
  assign w_active = r_pending & r_mask;

  assign w_off = bus.addr[2:0];
  assign w_sel = (bus.addr[15:3] == BASE_ADDR[15:3]);
  assign w_wr  = w_sel & ~bus.read_en;

  assign w_clr = { (w_wr && w_off == OFF_PEND_H) ? bus.din : 8'h00,
                   (w_wr && w_off == OFF_PEND_L) ? bus.din : 8'h00 };

  always_comb begin
    w_id = '0;
    w_id[ID_VALID_BIT]     = |w_active;
    w_id[ID_IDX_W-1:0]     = lowest_idx(w_active);
  end

  always_comb begin
    w_rdata = 8'h00;
    case (w_off)
      OFF_PEND_L:  w_rdata = r_pending[7:0];
      OFF_PEND_H:  w_rdata = r_pending[15:8];
      OFF_MASK_L:  w_rdata = r_mask[7:0];
      OFF_MASK_H:  w_rdata = r_mask[15:8];
      OFF_ID:      w_rdata = w_id;
      OFF_LEVEL_L: w_rdata = w_deb[7:0];
      OFF_LEVEL_H: w_rdata = w_deb[15:8];
      default:     w_rdata = 8'h00;
    endcase
  end

  assign bus.sel  = w_sel;
  assign bus.dout = w_sel ? w_rdata : 8'h00;
  assign irq      = r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb_q   <= '0;
      r_pending <= '0;
      r_mask    <= MASK_RST;
      r_irq     <= 1'b0;
    end else begin
      r_deb_q   <= w_deb;
      // A rise in the same cycle as a clear keeps the bit set so no press is lost.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (w_wr && w_off == OFF_MASK_L) r_mask[7:0]  <= bus.din;
      if (w_wr && w_off == OFF_MASK_H) r_mask[15:8] <= bus.din;
      r_irq     <= |w_active;
    end
  end

endmodule
